// File: rtl/slow_vram_slot_sched.sv
// Slot scheduler for the slow VRAM port. It runs a repeating frame of SLOTS slots.
// Each slot is owned by a read channel or by the CPU, and the owner is decided on entry to the slot.
module slow_vram_slot_sched #(
  parameter int AW        = 15,
  parameter int DW        = 16,
  parameter int WIDE      = 0,
  parameter int NCH       = 3,
  parameter int SLOTS     = 8,
  parameter int SLOT_LEN  = 4,
  parameter int CW        = $clog2(NCH + 2),
  parameter logic [SLOTS*CW-1:0] SLOT_MAP = '0,
  parameter int CPU_STEAL = 0
) (
  input  logic                          CLK_24M,
  input  logic                          RESETP,
  input  logic                          SYNC,
  input  logic [NCH-1:0]                CH_EN,
  input  logic [NCH*AW-1:0]             CH_ADDR,
  output logic [NCH*DW*(WIDE+1)-1:0]    CH_DATA,
  output logic [NCH-1:0]                CH_VALID,
  input  logic                          CPU_REQ,
  input  logic                          CPU_WE,
  input  logic [AW-1:0]                 CPU_ADDR,
  input  logic [DW-1:0]                 CPU_WDATA,
  output logic                          CPU_ACK,
  output logic [DW-1:0]                 CPU_RDATA,
  output logic [AW-1:0]                 SVRAM_ADDR,
  output logic [DW-1:0]                 SVRAM_DATA_OUT,
  input  logic [DW*(WIDE+1)-1:0]        SVRAM_DATA_IN,
  output logic                          BOE,
  output logic                          BWE,
  output logic [CW-1:0]                 VRAM_CYCLE,
  output logic [$clog2(SLOTS)-1:0]      SLOT_IDX
);
  localparam int RW = DW * (WIDE + 1);
  localparam int PW = $clog2(SLOT_LEN);
  localparam int SW = $clog2(SLOTS);
  localparam logic [PW-1:0] PH_LAST    = PW'(SLOT_LEN - 1);
  localparam logic [PW-1:0] PH_WE_LAST = PW'(SLOT_LEN - 2);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(SLOTS - 1);
  localparam logic [CW-1:0] CODE_CPU   = CW'(NCH);
  localparam logic [CW-1:0] CODE_IDLE  = CW'(NCH + 1);

  typedef enum logic [1:0] {K_IDLE, K_CH_RD, K_CPU_RD, K_CPU_WR} kind_t;

  logic [PW-1:0]     r_phase, w_phase_nxt;
  logic [SW-1:0]     r_slot, w_slot_nxt;
  kind_t             r_kind, w_kind_nxt, w_dec_kind;
  logic [CW-1:0]     r_owner, w_owner_nxt, w_dec_owner, w_map_code;
  logic [AW-1:0]     r_addr, w_addr_nxt, w_dec_addr;
  logic [DW-1:0]     r_wdata, w_wdata_nxt;
  logic              r_boe, w_boe_nxt, r_bwe, w_bwe_nxt;
  logic [NCH*RW-1:0] r_ch_data, w_ch_data_nxt;
  logic [NCH-1:0]    r_ch_valid, w_ch_valid_nxt;
  logic [DW-1:0]     r_cpu_rdata, w_cpu_rdata_nxt;
  logic              r_cpu_ack, w_cpu_ack_nxt;
  logic              w_last, w_enter0, w_cpu_take, w_done;

  always_comb begin
    w_last      = (r_phase == PH_LAST);
    w_enter0    = SYNC || w_last;
    w_phase_nxt = w_enter0 ? '0 : r_phase + PW'(1);
    if (SYNC)        w_slot_nxt = '0;
    else if (w_last) w_slot_nxt = (r_slot == SLOT_LAST) ? '0 : r_slot + SW'(1);
    else             w_slot_nxt = r_slot;

    w_map_code = CODE_IDLE;
    for (int i = 0; i < SLOTS; i++)
      if (w_slot_nxt == SW'(i)) w_map_code = SLOT_MAP[i*CW +: CW];

    // Owner for the slot being entered; an idle slot keeps the previous address.
    w_dec_kind  = K_IDLE;
    w_dec_owner = CODE_IDLE;
    w_dec_addr  = r_addr;
    w_cpu_take  = (w_map_code == CODE_CPU) && CPU_REQ;
    for (int k = 0; k < NCH; k++) begin
      if (w_map_code == CW'(k)) begin
        if (CH_EN[k]) begin
          w_dec_kind  = K_CH_RD;
          w_dec_owner = CW'(k);
          w_dec_addr  = CH_ADDR[k*AW +: AW];
        end else if (CPU_STEAL != 0) begin
          w_cpu_take = CPU_REQ;
        end
      end
    end
    if (w_cpu_take) begin
      w_dec_kind  = CPU_WE ? K_CPU_WR : K_CPU_RD;
      w_dec_owner = CODE_CPU;
      w_dec_addr  = CPU_ADDR;
    end

    w_kind_nxt  = r_kind;
    w_owner_nxt = r_owner;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    if (w_enter0) begin
      w_kind_nxt  = w_dec_kind;
      w_owner_nxt = w_dec_owner;
      w_addr_nxt  = w_dec_addr;
      if (w_cpu_take) w_wdata_nxt = CPU_WDATA;
    end

    w_boe_nxt = !(w_kind_nxt == K_CH_RD || w_kind_nxt == K_CPU_RD);
    // The write strobe skips the first and last phase so that address and data get setup and hold time.
    w_bwe_nxt = !(w_kind_nxt == K_CPU_WR && w_phase_nxt != '0 && w_phase_nxt <= PH_WE_LAST);

    // A slot completes only when it runs to its last phase. A slot cut short by SYNC does not complete.
    w_done          = w_last && !SYNC;
    w_ch_data_nxt   = r_ch_data;
    w_ch_valid_nxt  = '0;
    w_cpu_rdata_nxt = r_cpu_rdata;
    w_cpu_ack_nxt   = 1'b0;
    if (w_done) begin
      case (r_kind)
        K_CH_RD: begin
          for (int k = 0; k < NCH; k++) begin
            if (r_owner == CW'(k)) begin
              w_ch_data_nxt[k*RW +: RW] = SVRAM_DATA_IN;
              w_ch_valid_nxt[k]         = 1'b1;
            end
          end
        end
        K_CPU_RD: begin
          w_cpu_rdata_nxt = SVRAM_DATA_IN[DW-1:0];
          w_cpu_ack_nxt   = 1'b1;
        end
        K_CPU_WR: w_cpu_ack_nxt = 1'b1;
        default:  w_cpu_ack_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK_24M or posedge RESETP) begin
    if (RESETP) begin
      r_phase     <= '0;
      r_slot      <= '0;
      r_kind      <= K_IDLE;
      r_owner     <= CODE_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_boe       <= 1'b1;
      r_bwe       <= 1'b1;
      r_ch_data   <= '0;
      r_ch_valid  <= '0;
      r_cpu_rdata <= '0;
      r_cpu_ack   <= 1'b0;
    end else begin
      r_phase     <= w_phase_nxt;
      r_slot      <= w_slot_nxt;
      r_kind      <= w_kind_nxt;
      r_owner     <= w_owner_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_boe       <= w_boe_nxt;
      r_bwe       <= w_bwe_nxt;
      r_ch_data   <= w_ch_data_nxt;
      r_ch_valid  <= w_ch_valid_nxt;
      r_cpu_rdata <= w_cpu_rdata_nxt;
      r_cpu_ack   <= w_cpu_ack_nxt;
    end
  end

  assign CH_DATA        = r_ch_data;
  assign CH_VALID       = r_ch_valid;
  assign CPU_ACK        = r_cpu_ack;
  assign CPU_RDATA      = r_cpu_rdata;
  assign SVRAM_ADDR     = r_addr;
  assign SVRAM_DATA_OUT = r_wdata;
  assign BOE            = r_boe;
  assign BWE            = r_bwe;
  assign VRAM_CYCLE     = r_owner;
  assign SLOT_IDX       = r_slot;
endmodule

// File: tb/tb_slow_vram_slot_sched.sv
// Directed bench for slow_vram_slot_sched. Two instances share the stimulus:
// u_a is 16-bit with no stealing, and u_b is 32-bit with stealing.
module tb_slow_vram_slot_sched;
  localparam int AW = 15, DW = 16, NCH = 2, SLOTS = 4, SLOT_LEN = 4, CW = 2;
  localparam logic [7:0] MAP = 8'h98;  // slot0:ch0 slot1:CPU slot2:ch1 slot3:CPU

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, sync, cpu_we, req_a, req_b;
  logic [1:0]    ch_en;
  logic [29:0]   ch_addr;
  logic [14:0]   cpu_addr;
  logic [15:0]   cpu_wdata;

  logic [31:0] a_ch_data;  logic [1:0] a_ch_valid;  logic a_ack;  logic [15:0] a_rdata;
  logic [14:0] a_addr;     logic [15:0] a_dout;     logic [15:0] a_din;
  logic a_boe, a_bwe;      logic [1:0] a_vc, a_slot;
  logic [63:0] b_ch_data;  logic [1:0] b_ch_valid;  logic b_ack;  logic [15:0] b_rdata;
  logic [14:0] b_addr;     logic [15:0] b_dout, b_d; logic [31:0] b_din;
  logic b_boe, b_bwe;      logic [1:0] b_vc, b_slot;

  // VRAM model: 5A00^addr, and for the wide instance the inverted copy sits in the upper half.
  assign a_din = 16'h5A00 ^ {1'b0, a_addr};
  assign b_d   = 16'h5A00 ^ {1'b0, b_addr};
  assign b_din = {~b_d, b_d};

  slow_vram_slot_sched #(.AW(AW), .DW(DW), .WIDE(0), .NCH(NCH), .SLOTS(SLOTS),
    .SLOT_LEN(SLOT_LEN), .CW(CW), .SLOT_MAP(MAP), .CPU_STEAL(0)) u_a (
    .CLK_24M(clk), .RESETP(rst), .SYNC(sync), .CH_EN(ch_en), .CH_ADDR(ch_addr),
    .CH_DATA(a_ch_data), .CH_VALID(a_ch_valid), .CPU_REQ(req_a), .CPU_WE(cpu_we),
    .CPU_ADDR(cpu_addr), .CPU_WDATA(cpu_wdata), .CPU_ACK(a_ack), .CPU_RDATA(a_rdata),
    .SVRAM_ADDR(a_addr), .SVRAM_DATA_OUT(a_dout), .SVRAM_DATA_IN(a_din),
    .BOE(a_boe), .BWE(a_bwe), .VRAM_CYCLE(a_vc), .SLOT_IDX(a_slot));

  slow_vram_slot_sched #(.AW(AW), .DW(DW), .WIDE(1), .NCH(NCH), .SLOTS(SLOTS),
    .SLOT_LEN(SLOT_LEN), .CW(CW), .SLOT_MAP(MAP), .CPU_STEAL(1)) u_b (
    .CLK_24M(clk), .RESETP(rst), .SYNC(sync), .CH_EN(ch_en), .CH_ADDR(ch_addr),
    .CH_DATA(b_ch_data), .CH_VALID(b_ch_valid), .CPU_REQ(req_b), .CPU_WE(cpu_we),
    .CPU_ADDR(cpu_addr), .CPU_WDATA(cpu_wdata), .CPU_ACK(b_ack), .CPU_RDATA(b_rdata),
    .SVRAM_ADDR(b_addr), .SVRAM_DATA_OUT(b_dout), .SVRAM_DATA_IN(b_din),
    .BOE(b_boe), .BWE(b_bwe), .VRAM_CYCLE(b_vc), .SLOT_IDX(b_slot));

  int n_chk = 0;
  int n_err = 0;
  int m_ph  = 0;
  int m_sl  = 0;
  logic [1:0] vc_tab [4] = '{2'd0, 2'd3, 2'd1, 2'd3};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock. The bench keeps its own slot/phase position, and SYNC forces it back to slot 0.
  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      if (sync) begin
        m_ph = 0; m_sl = 0;
      end else if (m_ph == SLOT_LEN - 1) begin
        m_ph = 0; m_sl = (m_sl + 1) % SLOTS;
      end else begin
        m_ph++;
      end
      @(negedge clk);
    end
  endtask

  task automatic goto(input int s, input int p);
    int guard = 0;
    while (!(m_sl == s && m_ph == p) && guard < 64) begin
      step(1);
      guard++;
    end
    if (guard >= 64) begin
      n_chk++; n_err++;
      $error("FAIL goto: observed timeout expected slot %0d phase %0d", s, p);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bwe_lo, boe_lo, ack_seen;
    logic [1:0] vsum;
    logic [5:0] exp_t;
    rst = 1'b1; sync = 1'b0; ch_en = 2'b11; ch_addr = {15'h0123, 15'h7000};
    req_a = 1'b0; req_b = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_vc",     a_vc, 3);
    chk("rst_boe",    a_boe, 1);
    chk("rst_bwe",    a_bwe, 1);
    chk("rst_addr",   a_addr, 0);
    chk("rst_slot",   a_slot, 0);
    chk("rst_chdata", b_ch_data, 0);
    rst = 1'b0; m_ph = 0; m_sl = 0;

    // Free run: slot 0 after release is idle, then ch0/idle/ch1/idle repeats.
    for (int n = 1; n <= 32; n++) begin
      step(1);
      exp_t[5:4] = 2'((n / 4) % 4);
      exp_t[3:2] = (n < 4) ? 2'd3 : vc_tab[(n / 4) % 4];
      exp_t[1]   = (n % 16 == 12);
      exp_t[0]   = (n >= 16 && n % 16 == 4);
      chk("t1_slot_cycle_valid", {a_slot, a_vc, a_ch_valid}, exp_t);
    end
    chk("t1_d0",      a_ch_data[15:0], 16'h2A00);
    chk("t1_d1",      a_ch_data[31:16], 16'h5B23);
    chk("t1_wide_d0", b_ch_data[31:0], 32'hD5FF2A00);
    chk("t1_wide_d1", b_ch_data[63:32], 32'hA4DC5B23);

    // CPU write raised in slot 0, serviced in slot 1.
    step(1);
    req_a = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h1234; cpu_wdata = 16'hBEEF;
    goto(1, 0);
    chk("t2_vc",   a_vc, 2);
    chk("t2_addr", a_addr, 15'h1234);
    chk("t2_dout", a_dout, 16'hBEEF);
    chk("t2_boe",  a_boe, 1);
    bwe_lo = 0; ack_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (!a_bwe) bwe_lo++;
      if (a_ack) ack_seen++;
      chk("t2_bwe_phase", a_bwe, (i == 1 || i == 2) ? 1'b0 : 1'b1);
      step(1);
    end
    chk("t2_bwe_count",   bwe_lo, 2);
    chk("t2_ack_in_slot", ack_seen, 0);
    chk("t2_ack",         a_ack, 1);
    req_a = 1'b0;
    step(1);
    chk("t2_ack_pulse", a_ack, 0);
    goto(3, 0);
    chk("t2_no_repeat", a_vc, 3);

    // CPU read of 1234 in slot 1.
    step(1);
    req_a = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h1234;
    goto(1, 0);
    chk("t3_vc",   a_vc, 2);
    chk("t3_addr", a_addr, 15'h1234);
    boe_lo = 0; vsum = '0;
    for (int i = 0; i < 4; i++) begin
      if (!a_boe) boe_lo++;
      if (i > 0) vsum = vsum | a_ch_valid;
      step(1);
    end
    vsum = vsum | a_ch_valid;
    chk("t3_boe_count", boe_lo, 4);
    chk("t3_no_valid",  vsum, 0);
    chk("t3_ack",       a_ack, 1);
    chk("t3_rdata",     a_rdata, 16'h4834);
    req_a = 1'b0;

    // Stealing: ch1 disabled, and the read is raised at slot 1 phase 2.
    ch_en = 2'b01; cpu_addr = 15'h0456; cpu_we = 1'b0;
    goto(1, 2);
    req_a = 1'b1; req_b = 1'b1;
    goto(2, 0);
    chk("t4_steal_vc",   b_vc, 2);
    chk("t4_steal_boe",  b_boe, 0);
    chk("t4_nosteal_vc", a_vc, 3);
    chk("t4_nosteal_boe", a_boe, 1);
    goto(3, 0);
    chk("t4_steal_ack",   b_ack, 1);
    chk("t4_steal_rdata", b_rdata, 16'h5E56);
    chk("t4_nosteal_ack_early", a_ack, 0);
    chk("t4_nosteal_vc3", a_vc, 2);
    req_b = 1'b0;
    goto(0, 0);
    chk("t4_nosteal_ack",   a_ack, 1);
    chk("t4_nosteal_rdata", a_rdata, 16'h5E56);
    req_a = 1'b0;

    // SYNC at phase 1 of a CPU write slot.
    ch_en = 2'b00;
    step(1);
    req_a = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0ABC; cpu_wdata = 16'h1357;
    goto(1, 1);
    chk("t5_bwe_before", a_bwe, 0);
    sync = 1'b1;
    step(1);
    sync = 1'b0;
    chk("t5_bwe_abort", a_bwe, 1);
    chk("t5_slot",      a_slot, 0);
    chk("t5_ack_abort", a_ack, 0);
    chk("t5_vc_idle",   a_vc, 3);
    chk("t5_boe",       a_boe, 1);
    ack_seen = 0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (a_ack) ack_seen++;
    end
    chk("t5_no_ack_slot0", ack_seen, 0);
    chk("t5_vc_retry", a_vc, 2);
    chk("t5_addr",     a_addr, 15'h0ABC);
    chk("t5_dout",     a_dout, 16'h1357);
    step(1);
    chk("t5_bwe_retry", a_bwe, 0);
    goto(2, 0);
    chk("t5_ack", a_ack, 1);
    req_a = 1'b0;

    // Wide instance: reset pulsed in the middle of a write.
    ch_en = 2'b11;
    step(1);
    req_b = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0777; cpu_wdata = 16'h2468;
    goto(3, 1);
    chk("t6_bwe_active", b_bwe, 0);
    chk("t6_vc",         b_vc, 2);
    #1 rst = 1'b1;
    #1;
    chk("t6_async_bwe", b_bwe, 1);
    chk("t6_async_boe", b_boe, 1);
    @(negedge clk);
    req_b = 1'b0;
    chk("t6_rst_vc",     b_vc, 3);
    chk("t6_rst_addr",   b_addr, 0);
    chk("t6_rst_dout",   b_dout, 0);
    chk("t6_rst_data",   b_ch_data, 0);
    chk("t6_rst_valid",  b_ch_valid, 0);
    chk("t6_rst_rdata",  b_rdata, 0);
    chk("t6_rst_ack",    b_ack, 0);
    chk("t6_rst_slot",   b_slot, 0);
    rst = 1'b0; m_ph = 0; m_sl = 0;
    goto(1, 0);
    chk("t6_slot0_idle", b_ch_valid, 0);
    step(16);
    chk("t6_valid", b_ch_valid, 2'b01);
    chk("t6_data",  b_ch_data[31:0], 32'hD5FF2A00);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
